// File: rtl/phase_clock_gen.sv
// phase_clock_gen
//   Two-phase non-overlapping clock generator for the 6502 core and its bus
//   slaves. All logic runs on i_clk. The phase outputs are levels and strobes,
//   and are never used as clocks.
//
//   Optional feature macro: PHASE_CLOCK_GEN_CYCLE_COUNTER_EN
//     defined   -> o_cycle_count counts completed CPU cycles (wraps)
//     undefined -> o_cycle_count is tied to 0 (no counter flops)
//
//   Ports
//     i_clk          system clock
//     i_reset_n      asynchronous active-low reset
//     i_run          1 = free-run, 0 = halt at next cycle boundary
//     i_step         rising edge requests one CPU cycle while halted
//     i_rdy          0 = stretch current phi1 (sampled on its last clock)
//     o_phi1         phase 1 level
//     o_phi2         phase 2 level
//     o_phi1_start   one-clock pulse on first clock of phi1
//     o_phi2_end     one-clock pulse on last clock of phi2
//     o_halted       generator is halted
//     o_cycle_count  completed CPU cycles
module phase_clock_gen #(
    parameter int PHI1_W = 1,
    parameter int PHI2_W = 1,
    parameter int GAP_W  = 1,
    parameter int CNT_W  = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_rdy,
    output logic             o_phi1,
    output logic             o_phi2,
    output logic             o_phi1_start,
    output logic             o_phi2_end,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_cycle_count
);

    localparam int MAX_12 = (PHI1_W > PHI2_W) ? PHI1_W : PHI2_W;
    localparam int MAX_W  = (MAX_12 > GAP_W) ? MAX_12 : GAP_W;
    localparam int SC_W   = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    localparam logic [SC_W-1:0] PHI1_LAST = SC_W'(PHI1_W - 1);
    localparam logic [SC_W-1:0] PHI2_LAST = SC_W'(PHI2_W - 1);
    localparam logic [SC_W-1:0] GAP_LAST  = SC_W'(GAP_W - 1);

    typedef enum logic [2:0] {
        S_HALT,
        S_PHI1,
        S_GAP1,
        S_PHI2,
        S_GAP2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SC_W-1:0] sub;
    logic [SC_W-1:0] sub_nxt;

    logic step_s1;
    logic step_s2;
    logic step_d;
    logic step_rise;
    logic step_pending;

    assign step_rise = step_s2 & ~step_d;

    // Next-state decode; outputs below are registered from these values so
    // that each output matches the state it describes in the same clock.
    always_comb begin
        state_nxt = state;
        sub_nxt   = sub + 1'b1;
        case (state)
            S_HALT: begin
                sub_nxt = '0;
                if (i_run || step_pending)
                    state_nxt = S_PHI1;
            end
            S_PHI1: begin
                if (sub == PHI1_LAST) begin
                    if (i_rdy) begin
                        state_nxt = S_GAP1;
                        sub_nxt   = '0;
                    end else begin
                        // RDY low: hold on the last phi1 clock
                        sub_nxt = sub;
                    end
                end
            end
            S_GAP1: begin
                if (sub == GAP_LAST) begin
                    state_nxt = S_PHI2;
                    sub_nxt   = '0;
                end
            end
            S_PHI2: begin
                if (sub == PHI2_LAST) begin
                    state_nxt = S_GAP2;
                    sub_nxt   = '0;
                end
            end
            S_GAP2: begin
                if (sub == GAP_LAST) begin
                    state_nxt = i_run ? S_PHI1 : S_HALT;
                    sub_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_HALT;
                sub_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= S_HALT;
            sub          <= '0;
            step_s1      <= 1'b0;
            step_s2      <= 1'b0;
            step_d       <= 1'b0;
            step_pending <= 1'b0;
            o_phi1       <= 1'b0;
            o_phi2       <= 1'b0;
            o_phi1_start <= 1'b0;
            o_phi2_end   <= 1'b0;
            o_halted     <= 1'b0;
        end else begin
            state   <= state_nxt;
            sub     <= sub_nxt;
            step_s1 <= i_step;
            step_s2 <= step_s1;
            step_d  <= step_s2;

            // Step requests only latch while halted; entering phi1 consumes them.
            if (state_nxt == S_PHI1)
                step_pending <= 1'b0;
            else if (step_rise && state == S_HALT)
                step_pending <= 1'b1;

            o_phi1       <= (state_nxt == S_PHI1);
            o_phi2       <= (state_nxt == S_PHI2);
            // A stretch stays in PHI1, so the start strobe is not repeated.
            o_phi1_start <= (state_nxt == S_PHI1) && (state != S_PHI1);
            o_phi2_end   <= (state_nxt == S_PHI2) && (sub_nxt == PHI2_LAST);
            o_halted     <= (state_nxt == S_HALT);
        end
    end

`ifdef PHASE_CLOCK_GEN_CYCLE_COUNTER_EN
    logic [CNT_W-1:0] cycle_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            cycle_count <= '0;
        else if (o_phi2_end)
            cycle_count <= cycle_count + 1'b1;
    end

    assign o_cycle_count = cycle_count;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: doc/phase_clock_gen.md
Name: phase_clock_gen

Overview:
- Parametrised two-phase non-overlapping clock generator for the 6502 core and its bus slaves.
- Derives o_phi1/o_phi2 level phases plus single-clock sampling strobes from i_clk.
- Adds programmable phase and gap widths, run/halt, single-step, RDY stretch of phi1, and a CPU cycle counter.
- Sits between the mcu top and the core/bram; all logic is clocked by i_clk, and phases are never used as clocks.

Parameters:
- PHI1_W, 1, i_clk cycles phi1 is high per CPU cycle (>=1).
- PHI2_W, 1, i_clk cycles phi2 is high per CPU cycle (>=1).
- GAP_W, 1, dead i_clk cycles after each phase, both phases low (>=1).
- CNT_W, 32, width of o_cycle_count.

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  asynchronous active-low reset
- i_run  input  1  1 = free-run, 0 = halt at next cycle boundary
- i_step  input  1  rising edge requests exactly one CPU cycle while halted
- i_rdy  input  1  0 = stretch current phi1
- o_phi1  output  1  phase 1 level
- o_phi2  output  1  phase 2 level
- o_phi1_start  output  1  one-clock pulse on first clock of phi1
- o_phi2_end  output  1  one-clock pulse on last clock of phi2 (bus latch point)
- o_halted  output  1  state is HALT
- o_cycle_count  output  CNT_W  completed CPU cycles

Behaviour:
- Reset is asynchronous. It forces state HALT, sub-counter 0, step_pending 0, and all outputs 0 (o_halted reads 1 from the next state decode).
- States and widths: HALT; PHI1 (PHI1_W clocks); GAP1 (GAP_W); PHI2 (PHI2_W); GAP2 (GAP_W).
- Sub-counter: counts 0..W-1 inside each timed state and reloads 0 on every transition.
- Outputs are registered:
  - o_phi1 = (state==PHI1); o_phi2 = (state==PHI2).
  - Phases are never both high. They are separated by at least GAP_W low clocks.
- Nominal period = PHI1_W + GAP_W + PHI2_W + GAP_W clocks (default 4).
- HALT:
  - Go to PHI1 next clock if i_run=1 or step_pending=1; otherwise stay.
  - Entering PHI1 from any state clears step_pending.
- i_step:
  - Synchronised and edge-detected internally (2 flops plus an edge flop).
  - A detected rising edge sets step_pending only while in HALT. Edges while running are discarded.
- PHI1 last clock: if i_rdy=0, remain in PHI1 with the counter held at W-1 (phi1 stays high). Otherwise go to GAP1. i_rdy is sampled only on the last PHI1 clock.
- GAP1 to PHI2 to GAP2 are unconditional.
- GAP2 last clock (cycle boundary):
  - If i_run=1, go to PHI1.
  - Otherwise go to HALT.
  - A step-initiated cycle therefore executes once and returns to HALT.
- Clearing i_run mid-cycle never truncates phases; the current cycle completes.
- Strobes:
  - o_phi1_start = 1 on the first PHI1 clock only; not repeated during a stretch.
  - o_phi2_end = 1 on the last PHI2 clock; for PHI2_W=1 it coincides with o_phi2.
- o_cycle_count increments by 1 on the clock after o_phi2_end is asserted and wraps modulo 2^CNT_W.
- o_halted = (state==HALT).

Optional Feature:
- Macro: PHASE_CLOCK_GEN_CYCLE_COUNTER_EN.
- Defined: the counter is implemented as above.
- Undefined: o_cycle_count is tied to 0 and no counter flops are inferred.
- All other behaviour is identical with or without the macro.

Test Plan:
- Defaults, reset released with i_run=1, i_rdy=1 -> phi1 high 1 clk starting 1 clk after release, then pattern phi1/gap/phi2/gap repeating every 4 clks; o_phi1 & o_phi2 never both 1; after 10 cycles o_cycle_count=10 (macro defined).
- PHI1_W=2, PHI2_W=3, GAP_W=2 -> period 9 clks; phi1 high 2, phi2 high 3, 2 low clks between; o_phi2_end aligned with 3rd phi2 clk.
- i_rdy=0 held 5 clks across last PHI1 clock (defaults) -> phi1 stays high 6 clks total; single o_phi1_start; cycle period grows to 9; count still +1.
- i_run 1->0 mid-PHI2 -> cycle completes, o_halted=1 after GAP2; phases stay low; then 3 i_step pulses each 4 clks high, spaced 20 clks -> exactly 3 more cycles, count +3; i_step pulse while running -> no extra cycle, not remembered after halt.
- Assert i_reset_n=0 mid-PHI2 -> o_phi2 drops asynchronously; all outputs 0; HALT on release until i_run=1.
- CNT_W=4, run 17 cycles -> o_cycle_count=1 (wrap); rebuild without macro -> o_cycle_count stays 0, phase waveform identical.
